// File: rtl/rvfi_trace_buffer_pkg.sv
// Record layout helpers and shared types for the RVFI trace capture buffer.
// Fields are packed LSB-first: order, insn, pc_rdata, pc_wdata, rd_addr, rd_wdata, mem_addr, mem_wmask.
package rvfi_trace_pkg;

    typedef enum logic {TB_STOP = 1'b0, TB_WRAP = 1'b1} tb_mode_e;

    function automatic int rec_w(input int xlen);
        return 64 + 32 + 4 * xlen + 5 + xlen / 8;
    endfunction

    function automatic int off_order(input int xlen);
        return 0 * xlen;
    endfunction
    function automatic int off_insn(input int xlen);
        return 64 + 0 * xlen;
    endfunction
    function automatic int off_pc_r(input int xlen);
        return 96 + 0 * xlen;
    endfunction
    function automatic int off_pc_w(input int xlen);
        return 96 + xlen;
    endfunction
    function automatic int off_rd_addr(input int xlen);
        return 96 + 2 * xlen;
    endfunction
    function automatic int off_rd_wdata(input int xlen);
        return 101 + 2 * xlen;
    endfunction
    function automatic int off_mem_addr(input int xlen);
        return 101 + 3 * xlen;
    endfunction
    function automatic int off_mem_wmask(input int xlen);
        return 101 + 4 * xlen;
    endfunction

    localparam int REC_W_MAX = 64 + 32 + 4 * 64 + 5 + 8;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic [63:0] pc_rdata;
        logic [63:0] pc_wdata;
        logic [4:0]  rd_addr;
        logic [63:0] rd_wdata;
        logic [63:0] mem_addr;
        logic [7:0]  mem_wmask;
    } trace_rec_t;

    function automatic logic [63:0] xlen_mask(input int xlen);
        return (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [7:0] wmask_mask(input int xlen);
        return (xlen == 64) ? 8'hFF : 8'h0F;
    endfunction

    function automatic logic [REC_W_MAX-1:0] pack_rec(input int xlen, input trace_rec_t r);
        logic [REC_W_MAX-1:0] v;
        logic [63:0]          m;
        m = xlen_mask(xlen);
        v = '0;
        v = v | (REC_W_MAX'(r.order) << off_order(xlen));
        v = v | (REC_W_MAX'(r.insn) << off_insn(xlen));
        v = v | (REC_W_MAX'(r.pc_rdata & m) << off_pc_r(xlen));
        v = v | (REC_W_MAX'(r.pc_wdata & m) << off_pc_w(xlen));
        v = v | (REC_W_MAX'(r.rd_addr) << off_rd_addr(xlen));
        v = v | (REC_W_MAX'(r.rd_wdata & m) << off_rd_wdata(xlen));
        v = v | (REC_W_MAX'(r.mem_addr & m) << off_mem_addr(xlen));
        v = v | (REC_W_MAX'(r.mem_wmask & wmask_mask(xlen)) << off_mem_wmask(xlen));
        return v;
    endfunction

    function automatic trace_rec_t unpack_rec(input int xlen, input logic [REC_W_MAX-1:0] v);
        trace_rec_t           r;
        logic [REC_W_MAX-1:0] t;
        logic [63:0]          m;
        m           = xlen_mask(xlen);
        t           = v >> off_order(xlen);
        r.order     = t[63:0];
        t           = v >> off_insn(xlen);
        r.insn      = t[31:0];
        t           = v >> off_pc_r(xlen);
        r.pc_rdata  = t[63:0] & m;
        t           = v >> off_pc_w(xlen);
        r.pc_wdata  = t[63:0] & m;
        t           = v >> off_rd_addr(xlen);
        r.rd_addr   = t[4:0];
        t           = v >> off_rd_wdata(xlen);
        r.rd_wdata  = t[63:0] & m;
        t           = v >> off_mem_addr(xlen);
        r.mem_addr  = t[63:0] & m;
        t           = v >> off_mem_wmask(xlen);
        r.mem_wmask = t[7:0] & wmask_mask(xlen);
        return r;
    endfunction

endpackage

// File: rtl/rvfi_trace_buffer_mem.sv
// Storage array for the trace FIFO: one synchronous write port, one asynchronous read port.
module trace_fifo_mem #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem_r [DEPTH];

    // Record write
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/rvfi_trace_buffer.sv
// RVFI retirement capture FIFO with stop-on-full / overwrite-oldest modes and drop accounting.
// Optional macro ORDER_CHECK_EN enables the sticky retirement-order discontinuity flag.
module rvfi_trace_buffer
    import rvfi_trace_pkg::*;
#(
    parameter int  XLEN  = 32,
    parameter int  DEPTH = 16,
    parameter int  CNT_W = 16,
    localparam int REC_W = rec_w(XLEN),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                clear,
    input  logic                capture_en,
    input  logic                wrap_mode,
    input  logic                in_valid,
    input  logic [63:0]         in_order,
    input  logic [XLEN-1:0]     in_pc_rdata,
    input  logic [XLEN-1:0]     in_pc_wdata,
    input  logic [31:0]         in_insn,
    input  logic [4:0]          in_rd_addr,
    input  logic [XLEN-1:0]     in_rd_wdata,
    input  logic [XLEN-1:0]     in_mem_addr,
    input  logic [XLEN/8-1:0]   in_mem_wmask,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [REC_W-1:0]    out_rec,
    output logic [CW-1:0]       count,
    output logic                overflow,
    output logic [CNT_W-1:0]    drop_count,
    output logic                order_err
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_r, rd_ptr_r, wr_ptr_nx_s, rd_ptr_nx_s;
    logic [CW-1:0]    count_r, count_nx_s;
    logic             out_valid_r, overflow_r;
    logic [CNT_W-1:0] drop_count_r;
    logic             push_s, pop_s, full_s, we_s, drop_s, mem_we_s;
    logic [REC_W-1:0] wr_rec_s;
    tb_mode_e         mode_s;

    function automatic logic [PW-1:0] ptr_adv(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign mode_s   = tb_mode_e'(wrap_mode);
    assign push_s   = in_valid & capture_en;
    assign pop_s    = out_valid_r & out_ready;
    assign full_s   = (count_r == CW'(DEPTH));
    assign wr_rec_s = {in_mem_wmask, in_mem_addr, in_rd_wdata, in_rd_addr,
                       in_pc_wdata, in_pc_rdata, in_insn, in_order};
    assign mem_we_s = we_s & ~Reset & ~clear;

    // Next pointer/count and drop decision for the current push/pop combination
    always_comb begin
        we_s        = 1'b0;
        drop_s      = 1'b0;
        wr_ptr_nx_s = wr_ptr_r;
        rd_ptr_nx_s = rd_ptr_r;
        count_nx_s  = count_r;
        if (push_s && (!full_s || pop_s)) begin
            we_s        = 1'b1;
            wr_ptr_nx_s = ptr_adv(wr_ptr_r);
            if (pop_s) begin
                rd_ptr_nx_s = ptr_adv(rd_ptr_r);
            end else begin
                count_nx_s = count_r + CW'(1);
            end
        end else if (push_s) begin
            drop_s = 1'b1;
            // Full with no pop: overwrite the oldest entry or discard the new one
            if (mode_s == TB_WRAP) begin
                we_s        = 1'b1;
                wr_ptr_nx_s = ptr_adv(wr_ptr_r);
                rd_ptr_nx_s = ptr_adv(rd_ptr_r);
            end else begin
                we_s = 1'b0;
            end
        end else if (pop_s) begin
            rd_ptr_nx_s = ptr_adv(rd_ptr_r);
            count_nx_s  = count_r - CW'(1);
        end else begin
            we_s = 1'b0;
        end
    end

    // Pointer, occupancy and loss-accounting registers
    always_ff @(posedge CLK) begin
        if (Reset || clear) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            out_valid_r  <= 1'b0;
            overflow_r   <= 1'b0;
            drop_count_r <= '0;
        end else begin
            wr_ptr_r    <= wr_ptr_nx_s;
            rd_ptr_r    <= rd_ptr_nx_s;
            count_r     <= count_nx_s;
            out_valid_r <= (count_nx_s != '0);
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_count_r != {CNT_W{1'b1}}) begin
                    drop_count_r <= drop_count_r + CNT_W'(1);
                end
            end
        end
    end

    trace_fifo_mem #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (CLK),
        .we      (mem_we_s),
        .wr_addr (wr_ptr_r),
        .wr_data (wr_rec_s),
        .rd_addr (rd_ptr_r),
        .rd_data (out_rec)
    );

`ifdef ORDER_CHECK_EN
    logic [63:0] last_order_r;
    logic        have_base_r, order_err_r;

    // Retirement-order continuity tracking, independent of capture_en
    always_ff @(posedge CLK) begin
        if (Reset || clear) begin
            last_order_r <= 64'd0;
            have_base_r  <= 1'b0;
            order_err_r  <= 1'b0;
        end else if (in_valid) begin
            last_order_r <= in_order;
            have_base_r  <= 1'b1;
            if (have_base_r && (in_order != last_order_r + 64'd1)) begin
                order_err_r <= 1'b1;
            end
        end
    end

    assign order_err = order_err_r;
`else
    assign order_err = 1'b0;
`endif

    assign out_valid  = out_valid_r;
    assign count      = count_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

endmodule
